// File: rtl/myproject_mac_accum_requant.sv
// Multiply-accumulate tail: sums signed products into a wide accumulator, then
// adds bias, rounds half-up, saturates (optionally ReLU) and hands off one result per sum.
module myproject_mac_accum_requant #(
  parameter int PROD_WIDTH = 27,
  parameter int ACC_WIDTH  = 38,
  parameter int OUT_WIDTH  = 16,
  parameter int FRAC_SHIFT = 10,
  parameter int MAX_TAPS   = 2048,
  parameter bit RELU_EN    = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic [PROD_WIDTH-1:0] prod_in,
  input  logic                  prod_valid,
  input  logic                  prod_last,
  output logic                  prod_ready,
  input  logic [OUT_WIDTH-1:0]  bias,
  output logic [OUT_WIDTH-1:0]  out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  overrun
);
  localparam int CW = $clog2(MAX_TAPS + 1);
  // Requant sum is widened so bias<<FRAC_SHIFT and the round constant never overflow.
  localparam int SW = ACC_WIDTH + OUT_WIDTH + 2;
  localparam logic signed [SW-1:0] RND  = {{(SW-FRAC_SHIFT){1'b0}}, 1'b1, {(FRAC_SHIFT-1){1'b0}}};
  localparam logic signed [SW-1:0] OMAX = {{(SW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [SW-1:0] OMIN = {{(SW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACCUM, EMIT} state_t;
  state_t state, state_n;

  logic signed [ACC_WIDTH-1:0] acc, acc_next, prod_x;
  logic [CW-1:0]               tap_cnt, cnt_next;
  logic                        accept, xfer, start, hit_max, close, forced;
  logic signed [SW-1:0]        bias_x, s, r;
  logic signed [OUT_WIDTH-1:0] sat, res;

  assign prod_ready = (state != EMIT) | out_ready;
  assign accept     = ce & prod_valid & prod_ready;
  assign xfer       = ce & out_valid & out_ready;

  // Any accept outside ACCUM opens a fresh sum (IDLE, or EMIT during its transfer).
  assign start    = (state != ACCUM);
  assign prod_x   = ACC_WIDTH'($signed(prod_in));
  assign acc_next = start ? prod_x : acc + prod_x;
  assign cnt_next = start ? CW'(1) : tap_cnt + CW'(1);
  assign hit_max  = (cnt_next == CW'(MAX_TAPS));
  assign close    = accept & (prod_last | hit_max);
  assign forced   = accept & ~prod_last & hit_max;

  assign bias_x = SW'($signed(bias));
  assign s      = SW'(acc_next) + (bias_x <<< FRAC_SHIFT) + RND;
  assign r      = s >>> FRAC_SHIFT;

  always_comb begin
    sat = r[OUT_WIDTH-1:0];
    if (r > OMAX)      sat = OMAX[OUT_WIDTH-1:0];
    else if (r < OMIN) sat = OMIN[OUT_WIDTH-1:0];
    res = sat;
    if (RELU_EN && sat[OUT_WIDTH-1]) res = '0;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept) state_n = close ? EMIT : ACCUM;
      ACCUM:   if (close)  state_n = EMIT;
      EMIT:    if (xfer)   state_n = accept ? (close ? EMIT : ACCUM) : IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      acc       <= '0;
      tap_cnt   <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        acc     <= acc_next;
        tap_cnt <= cnt_next;
      end
      if (close) out_data <= res;
      if (close)     out_valid <= 1'b1;
      else if (xfer) out_valid <= 1'b0;
      if (forced) overrun <= 1'b1;
    end
  end
endmodule

// File: tb/tb_myproject_mac_accum_requant.sv
// Directed bench: default instance (a) plus a MAX_TAPS=4, RELU_EN=1 instance (b) on shared inputs.
module tb_myproject_mac_accum_requant;
  logic clk = 1'b0, reset = 1'b1, ce = 1'b1;
  logic [26:0] prod_in = '0;
  logic prod_valid = 1'b0, prod_last = 1'b0, out_ready = 1'b1;
  logic [15:0] bias = '0;
  logic [15:0] out_a, out_b;
  logic vld_a, vld_b, rdy_a, rdy_b, ovr_a, ovr_b;
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  myproject_mac_accum_requant dut_a (
    .clk(clk), .reset(reset), .ce(ce), .prod_in(prod_in), .prod_valid(prod_valid),
    .prod_last(prod_last), .prod_ready(rdy_a), .bias(bias), .out_data(out_a),
    .out_valid(vld_a), .out_ready(out_ready), .overrun(ovr_a));

  myproject_mac_accum_requant #(.MAX_TAPS(4), .RELU_EN(1'b1)) dut_b (
    .clk(clk), .reset(reset), .ce(ce), .prod_in(prod_in), .prod_valid(prod_valid),
    .prod_last(prod_last), .prod_ready(rdy_b), .bias(bias), .out_data(out_b),
    .out_valid(vld_b), .out_ready(out_ready), .overrun(ovr_b));

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic beat(input int p, input bit last);
    prod_valid = 1'b1; prod_in = 27'(p); prod_last = last;
    tick();
    prod_valid = 1'b0; prod_last = 1'b0;
  endtask

  initial begin
    // reset state
    #1;
    chk("rst_data", out_a, 0);
    chk("rst_vld", vld_a, 0);
    chk("rst_ovr", ovr_a, 0);
    chk("rst_rdy", rdy_a, 1);
    tick(); reset = 1'b0;

    // rounding: 1024+2048-512 = 2560 -> 3
    beat(1024, 0);
    beat(2048, 0);
    chk("round_lat_pre", vld_a, 0);
    beat(-512, 1);
    chk("round_vld", vld_a, 1);
    chk("round_data", $signed(out_a), 3);
    tick();
    chk("round_vld_drop", vld_a, 0);

    // saturation
    beat(40000000, 0); beat(40000000, 1);
    chk("sat_pos", $signed(out_a), 32767);
    tick();
    beat(-40000000, 0); beat(-40000000, 1);
    chk("sat_neg", $signed(out_a), -32768);
    chk("sat_neg_relu", $signed(out_b), 0);
    tick();

    // bias with single-tap sums from IDLE
    bias = 16'd5; beat(0, 1);
    chk("bias5", $signed(out_a), 5);
    tick();
    bias = 16'hFFFF; beat(511, 1);
    chk("bias_m1", $signed(out_a), -1);
    chk("bias_m1_relu", $signed(out_b), 0);
    tick();
    bias = '0;

    // backpressure: 1024+2048 -> 3 held while out_ready=0; offered product must wait
    beat(1024, 0);
    out_ready = 1'b0;
    beat(2048, 1);
    prod_valid = 1'b1; prod_in = 27'd4096; prod_last = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("bp_data", $signed(out_a), 3);
      chk("bp_vld", vld_a, 1);
      chk("bp_rdy", rdy_a, 0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    prod_valid = 1'b0;
    chk("bp_xfer_vld", vld_a, 0);
    beat(1024, 1);
    chk("bp_nobubble", $signed(out_a), 5);
    // closing single-tap beat during a transfer reloads the output
    beat(2048, 1);
    chk("reload_vld", vld_a, 1);
    chk("reload_data", $signed(out_a), 2);
    tick();
    chk("reload_drop", vld_a, 0);

    // ce gating mid-sum and in EMIT
    beat(1024, 0);
    ce = 1'b0; prod_valid = 1'b1; prod_in = 27'd9999; prod_last = 1'b1;
    tick();
    chk("ce_hold0", vld_a, 0);
    tick();
    chk("ce_hold1", vld_a, 0);
    ce = 1'b1; prod_valid = 1'b0; prod_last = 1'b0;
    beat(2048, 0); beat(-512, 1);
    chk("ce_data", $signed(out_a), 3);
    ce = 1'b0;
    tick();
    chk("ce_emit_vld", vld_a, 1);
    chk("ce_emit_data", $signed(out_a), 3);
    ce = 1'b1;
    tick();
    chk("ce_emit_drop", vld_a, 0);

    // overrun on the MAX_TAPS=4 instance
    reset = 1'b1; tick(); reset = 1'b0;
    for (int i = 0; i < 3; i++) beat(1024, 0);
    chk("ovr_pre", vld_b, 0);
    beat(1024, 0);
    chk("ovr_vld", vld_b, 1);
    chk("ovr_data", $signed(out_b), 4);
    chk("ovr_flag", ovr_b, 1);
    chk("ovr_a_clear", ovr_a, 0);
    beat(1024, 0);
    chk("ovr_newsum", vld_b, 0);
    chk("ovr_sticky", ovr_b, 1);

    // asynchronous reset mid-sum
    #2 reset = 1'b1; #1;
    chk("amid_data", out_b, 0);
    chk("amid_vld", vld_b, 0);
    chk("amid_ovr", ovr_b, 0);
    chk("amid_rdy", rdy_a, 1);
    tick(); reset = 1'b0;
    beat(1024, 1);
    chk("post_rst_a", $signed(out_a), 1);
    chk("post_rst_b", $signed(out_b), 1);
    chk("post_rst_ovr", ovr_b, 0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/myproject_mac_accum_requant.md
MYPROJECT_MAC_ACCUM_REQUANT -- requirements
Module: myproject_mac_accum_requant

Interface
REQ-001 Parameters SHALL be: PROD_WIDTH, 27, product width; ACC_WIDTH, 38, accumulator width; OUT_WIDTH, 16, output width; FRAC_SHIFT, 10, fractional bits removed at requantisation; MAX_TAPS, 2048, taps per sum before forced close; RELU_EN, 0, 1 clamps negative results to 0.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 ce  input  1  clock enable; when 0, all state holds.
REQ-005 prod_in  input  PROD_WIDTH  signed product from the upstream multiplier output register.
REQ-006 prod_valid  input  1  prod_in valid, already aligned to the multiplier latency.
REQ-007 prod_last  input  1  marks the final product of the current sum.
REQ-008 prod_ready  output  1  block can accept a product this cycle.
REQ-009 bias  input  OUT_WIDTH  signed bias, sampled on the accepted prod_last beat.
REQ-010 out_data  output  OUT_WIDTH  signed requantised result.
REQ-011 out_valid  output  1  out_data valid.
REQ-012 out_ready  input  1  downstream accepts out_data.
REQ-013 overrun  output  1  sticky flag: a sum was force-closed at MAX_TAPS.

Function
REQ-014 Accept SHALL mean ce=1 and prod_valid=1 and prod_ready=1; transfer SHALL mean ce=1 and out_valid=1 and out_ready=1.
REQ-015 States SHALL be IDLE, ACCUM and EMIT, with reset to IDLE.
REQ-016 prod_ready SHALL be 1 in IDLE and ACCUM, and SHALL equal out_ready in EMIT.
REQ-017 On an accept in IDLE, or in EMIT during a transfer: acc <= sext(prod_in), tap_cnt <= 1, next state ACCUM.
REQ-018 On an accept in ACCUM: acc <= acc + sext(prod_in), tap_cnt <= tap_cnt + 1.
REQ-019 The closing beat SHALL be any accept with prod_last=1, or any accept that makes tap_cnt equal MAX_TAPS; a forced close SHALL set overrun.
REQ-020 On the closing beat, in the same cycle: s = acc_next + (sext(bias) << FRAC_SHIFT) + (1 << (FRAC_SHIFT-1)); r = s >>> FRAC_SHIFT (arithmetic shift, round-half-up).
REQ-021 r SHALL saturate to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]; if RELU_EN=1, negative r SHALL become 0.
REQ-022 The result of REQ-021 SHALL be registered into out_data; out_valid <= 1; state <= EMIT.
REQ-023 Latency SHALL be 1 cycle from the closing accept to out_valid=1.
REQ-024 In EMIT, out_data and out_valid SHALL hold until a transfer.
REQ-025 On a transfer with no same-cycle accept: out_valid <= 0, state <= IDLE.
REQ-026 On a transfer with a same-cycle accept, REQ-017 SHALL apply.
REQ-027 If that same-cycle accept is also a closing beat, out_data SHALL reload and out_valid SHALL stay 1.
REQ-028 A prod_last beat accepted in IDLE SHALL be a one-tap sum.
REQ-029 With ce=0, no accept or transfer SHALL occur and all registers SHALL hold, including in EMIT.
REQ-030 The accumulator SHALL NOT wrap for MAX_TAPS full-scale products (ACC_WIDTH >= PROD_WIDTH + log2(MAX_TAPS)).

Reset
REQ-031 Asserting reset SHALL immediately drive: state=IDLE, acc=0, tap_cnt=0, out_data=0, out_valid=0, overrun=0. prod_ready=1 follows from IDLE.
REQ-032 Reset asserted mid-sum or mid-EMIT SHALL discard the partial sum and the pending output, with no output transfer.
REQ-033 The first accept after reset deassertion SHALL start a new sum.

Verification
REQ-034 Rounding: bias=0, products 1024, 2048, -512 (last on third), out_ready=1 -> out_data=3, out_valid for 1 cycle, 1 cycle after the last beat.
REQ-035 Saturation: products 40000000, 40000000 (last) -> out_data=32767; products -40000000 x2 -> -32768, or 0 when RELU_EN=1.
REQ-036 Bias and single tap: bias=5, single product 0 with last in IDLE -> out_data=5; bias=-1, product 511 -> out_data=-1 (511-1024+512=-1, >>>10 = -1).
REQ-037 Backpressure: sum closes, out_ready=0 for 3 cycles -> out_data stable, prod_ready=0; out_ready=1 with a new first product same cycle -> transfer, and the new sum starts with no bubble.
REQ-038 Overrun and reset: MAX_TAPS=4, five products of 1024 with no last -> output 4 after the fourth beat with overrun=1, and the fifth starts a new sum; reset asserted mid-sum -> all outputs 0 immediately, and a later sum of 1024 (last) -> 1.
REQ-039 ce gating: ce=0 for 2 cycles in the middle of a 3-product sum -> result identical to the ungated run, delayed 2 cycles.
